// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
// Provides widths, address/data types and the hardwired-zero index.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_cell.sv
// One write-enabled storage word of the register file.
// Ports: clk, reset (sync, active-high), wrEn, dataIn -> dataOut.
module reg_cell #(
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut <= '0;
        end else if (wrEn) begin
            dataOut <= dataIn;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 2-read/1-write register file with write bypass and pending-write scoreboard.
// Ports: clk, reset, rdEn/rdAddrA/rdAddrB -> dataOutA/B, busyA/B (registered);
//        regWr/wrAddr/dataIn write port; issueValid/issueAddr mark pending.
module reg_file #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] dataOutA,
    output logic [DATA_W-1:0] dataOutB,
    output logic              busyA,
    output logic              busyB,
    input  logic              regWr,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pendingNext;
    logic                wrLive;
    logic                hitA;
    logic                hitB;

    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
        reg_cell #(
            .DATA_W (DATA_W)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .wrEn    (regWr && (wrAddr == ADDR_W'(i))),
            .dataIn  (dataIn),
            .dataOut (regs[i])
        );
    end

    assign wrLive = regWr && (wrAddr != ZERO);
    assign hitA   = regWr && (wrAddr == rdAddrA);
    assign hitB   = regWr && (wrAddr == rdAddrB);

    // Set is applied after clear so a same-cycle reissue stays pending.
    always_comb begin
        pendingNext = pending;
        if (regWr) begin
            pendingNext[wrAddr] = 1'b0;
        end
        if (issueValid && (issueAddr != ZERO)) begin
            pendingNext[issueAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    // Busy reflects the post-bypass view: a write this cycle resolves it.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOutA <= '0;
            dataOutB <= '0;
            busyA    <= 1'b0;
            busyB    <= 1'b0;
        end else if (rdEn) begin
            dataOutA <= (wrLive && hitA) ? dataIn : regs[rdAddrA];
            dataOutB <= (wrLive && hitB) ? dataIn : regs[rdAddrB];
            busyA    <= pending[rdAddrA] && !hitA;
            busyB    <= pending[rdAddrB] && !hitB;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic
// compared each cycle against an array-based model of the register file.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdEn;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic [31:0] dataOutA;
    logic [31:0] dataOutB;
    logic        busyA;
    logic        busyB;
    logic        regWr;
    logic [4:0]  wrAddr;
    logic [31:0] dataIn;
    logic        issueValid;
    logic [4:0]  issueAddr;

    int passed = 0;
    int total  = 0;

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .rdEn       (rdEn),
        .rdAddrA    (rdAddrA),
        .rdAddrB    (rdAddrB),
        .dataOutA   (dataOutA),
        .dataOutB   (dataOutB),
        .busyA      (busyA),
        .busyB      (busyB),
        .regWr      (regWr),
        .wrAddr     (wrAddr),
        .dataIn     (dataIn),
        .issueValid (issueValid),
        .issueAddr  (issueAddr)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain arrays for contents and pending flags.
    logic [31:0] mem  [32];
    bit          pend [32];
    logic [31:0] expA;
    logic [31:0] expB;
    bit          expBusyA;
    bit          expBusyB;
    bit          modelValid = 0;

    always @(posedge clk) begin
        if (reset) begin
            foreach (mem[k]) mem[k] = 32'h0;
            foreach (pend[k]) pend[k] = 0;
            expA = 0;
            expB = 0;
            expBusyA = 0;
            expBusyB = 0;
            modelValid = 1;
        end else begin
            if (rdEn) begin
                if (regWr && wrAddr != 0 && wrAddr == rdAddrA)
                    expA = dataIn;
                else
                    expA = mem[rdAddrA];
                if (regWr && wrAddr != 0 && wrAddr == rdAddrB)
                    expB = dataIn;
                else
                    expB = mem[rdAddrB];
                expBusyA = pend[rdAddrA] && !(regWr && wrAddr == rdAddrA);
                expBusyB = pend[rdAddrB] && !(regWr && wrAddr == rdAddrB);
            end
            if (regWr && wrAddr != 0) mem[wrAddr] = dataIn;
            if (regWr) pend[wrAddr] = 0;
            if (issueValid && issueAddr != 0) pend[issueAddr] = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            check("model_dataOutA", dataOutA, expA);
            check("model_dataOutB", dataOutB, expB);
            check("model_busyA", {31'b0, busyA}, {31'b0, expBusyA});
            check("model_busyB", {31'b0, busyB}, {31'b0, expBusyB});
        end
    end

    task automatic idle();
        reset = 0;
        rdEn = 0;
        rdAddrA = 0;
        rdAddrB = 0;
        regWr = 0;
        wrAddr = 0;
        dataIn = 0;
        issueValid = 0;
        issueAddr = 0;
    endtask

    // Inputs set before the call are sampled by the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        idle();
        rdEn = 1;
        rdAddrA = a;
        rdAddrB = b;
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        idle();
        reset = 1;
        cyc();
        cyc();

        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            cyc();
        end
        check("reset_read_A", dataOutA, 32'h0);
        check("reset_read_B", dataOutB, 32'h0);
        check("reset_busy", {30'b0, busyA, busyB}, 32'h0);

        idle();
        regWr = 1; wrAddr = 5; dataIn = 32'hDEADBEEF;
        cyc();
        rd(5, 0);
        cyc();
        check("wr_rd_r5", dataOutA, 32'hDEADBEEF);

        rd(7, 7);
        regWr = 1; wrAddr = 7; dataIn = 32'h12345678;
        cyc();
        check("bypass_A", dataOutA, 32'h12345678);
        check("bypass_B", dataOutB, 32'h12345678);

        rd(0, 0);
        regWr = 1; wrAddr = 0; dataIn = 32'h12345678;
        cyc();
        check("bypass_r0_A", dataOutA, 32'h0);
        check("bypass_r0_B", dataOutB, 32'h0);

        idle();
        regWr = 1; wrAddr = 0; dataIn = 32'hFFFFFFFF;
        cyc();
        idle();
        issueValid = 1; issueAddr = 0;
        cyc();
        rd(0, 0);
        cyc();
        check("r0_data", dataOutA, 32'h0);
        check("r0_busy", {30'b0, busyA, busyB}, 32'h0);

        idle();
        issueValid = 1; issueAddr = 9;
        cyc();
        rd(0, 9);
        cyc();
        check("sb_issue_busyB", {31'b0, busyB}, 32'h1);

        rd(0, 9);
        regWr = 1; wrAddr = 9; dataIn = 32'hA5A5A5A5;
        cyc();
        check("sb_write_busyB", {31'b0, busyB}, 32'h0);
        check("sb_write_data", dataOutB, 32'hA5A5A5A5);

        idle();
        issueValid = 1; issueAddr = 9;
        regWr = 1; wrAddr = 9; dataIn = 32'h00000009;
        cyc();
        rd(0, 9);
        cyc();
        check("sb_set_wins", {31'b0, busyB}, 32'h1);

        rd(3, 5);
        regWr = 1; wrAddr = 3; dataIn = 32'h33;
        cyc();
        for (int s = 0; s < 3; s++) begin
            idle();
            rdAddrA = 7; rdAddrB = 9;
            regWr = 1; wrAddr = 3; dataIn = 32'(32'h40 + s);
            cyc();
            check("stall_A", dataOutA, 32'h33);
            check("stall_B", dataOutB, 32'hDEADBEEF);
        end
        rd(3, 3);
        cyc();
        check("after_stall_r3", dataOutA, 32'h42);

        idle();
        issueValid = 1; issueAddr = 3;
        cyc();
        rd(3, 4);
        reset = 1;
        regWr = 1; wrAddr = 3; dataIn = 32'h55;
        issueValid = 1; issueAddr = 4;
        cyc();
        check("reset_out_A", dataOutA, 32'h0);
        rd(3, 4);
        cyc();
        check("reset_r3", dataOutA, 32'h0);
        check("reset_pend", {30'b0, busyA, busyB}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            idle();
            reset      = ($urandom_range(0, 299) == 0);
            rdEn       = ($urandom_range(0, 3) != 0);
            rdAddrA    = raddr();
            rdAddrB    = raddr();
            regWr      = ($urandom_range(0, 1) == 1);
            wrAddr     = raddr();
            dataIn     = $urandom;
            issueValid = ($urandom_range(0, 2) == 0);
            issueAddr  = raddr();
            cyc();
        end

        idle();
        cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
